// File: rtl/mlblock_os_pkg.sv
// Shared types and helpers for the output-stationary MAC array.
// MLBLOCK_RES_SAT_EN selects saturating accumulation via sat_add.
package mlblock_os_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DRAIN
  } state_t;

  typedef struct packed {
    logic        sat;
    logic [63:0] sum;
  } sat_t;

  function automatic int cfg_len(input int k_w);
    return k_w + 1;
  endfunction

  // acc/p arrive already extended to 64 bits per sgn; res_w < 64
  function automatic sat_t sat_add(
    input logic [63:0] acc,
    input logic [63:0] p,
    input int          res_w,
    input logic        sgn
  );
    logic signed [65:0] s;
    logic signed [65:0] hi;
    logic signed [65:0] lo;
    sat_t r;
    if (sgn) begin
      s  = $signed({{2{acc[63]}}, acc})
         + $signed({{2{p[63]}}, p});
      hi = (66'sd1 <<< (res_w - 1)) - 66'sd1;
      lo = -(66'sd1 <<< (res_w - 1));
    end else begin
      s  = $signed({2'b00, acc})
         + $signed({2'b00, p});
      hi = (66'sd1 <<< res_w) - 66'sd1;
      lo = '0;
    end
    r.sat = 1'b0;
    r.sum = s[63:0];
    if (s > hi) begin
      r.sat = 1'b1;
      r.sum = hi[63:0];
    end else if (s < lo) begin
      r.sat = 1'b1;
      r.sum = lo[63:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/mlblock_os_array_if.sv
// Operand-in and result-out streams of the MAC array.
// master = producer/consumer side, slave = array side.
interface mlblock_os_array_if #(
  parameter int PE_H  = 4,
  parameter int PE_W  = 4,
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int RES_W = 32
);
  localparam int RW = (PE_H > 1) ? $clog2(PE_H) : 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [PE_H*A_W-1:0]   a;
  logic [PE_W*B_W-1:0]   b;
  logic                  res_valid;
  logic                  res_ready;
  logic [PE_W*RES_W-1:0] res;
  logic [RW-1:0]         res_row;

  modport master (
    output in_valid, a, b, res_ready,
    input  in_ready, res_valid, res, res_row
  );

  modport slave (
    input  in_valid, a, b, res_ready,
    output in_ready, res_valid, res, res_row
  );
endinterface

// File: rtl/mlblock_os_pe.sv
// One MAC PE: forwards a right and b down, accumulates a*b.
// MLBLOCK_RES_SAT_EN: saturate instead of wrap, report via sat.
module mlblock_os_pe
  import mlblock_os_pkg::*;
#(
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int RES_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             sgn,
  input  logic [A_W-1:0]   a_in,
  input  logic             a_vin,
  input  logic [B_W-1:0]   b_in,
  input  logic             b_vin,
  output logic [A_W-1:0]   a_out,
  output logic             a_vout,
  output logic [B_W-1:0]   b_out,
  output logic             b_vout,
  output logic [RES_W-1:0] acc,
  output logic             sat
);
  localparam int P_W = A_W + B_W + 2;

  logic signed [A_W:0]   as;
  logic signed [B_W:0]   bs;
  logic signed [P_W-1:0] prod;
  logic [RES_W-1:0]      pe;
  logic                  hit;

  // one extra bit makes a single signed multiply serve both modes
  assign as   = $signed({sgn & a_in[A_W-1], a_in});
  assign bs   = $signed({sgn & b_in[B_W-1], b_in});
  assign prod = P_W'(as) * P_W'(bs);
  assign pe   = RES_W'(prod);
  assign hit  = a_vin && b_vin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_out  <= '0;
      a_vout <= 1'b0;
      b_out  <= '0;
      b_vout <= 1'b0;
    end else begin
      a_out  <= a_in;
      a_vout <= a_vin;
      b_out  <= b_in;
      b_vout <= b_vin;
    end
  end

`ifdef MLBLOCK_RES_SAT_EN
  logic [63:0] acc_x;
  logic [63:0] p_x;
  sat_t        nx;

  assign acc_x = sgn ? 64'($signed(acc)) : 64'(acc);
  assign p_x   = sgn ? 64'($signed(pe)) : 64'(pe);
  assign nx    = sat_add(acc_x, p_x, RES_W, sgn);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (hit) begin
      acc <= nx.sum[RES_W-1:0];
      sat <= sat | nx.sat;
    end
  end
`else
  assign sat = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (hit) begin
      acc <= acc + pe;
    end
  end
`endif

endmodule

// File: rtl/mlblock_os_array.sv
// Output-stationary PE_H x PE_W MAC array with skewed feed and row drain.
// MLBLOCK_RES_SAT_EN: saturating accumulators and live sat_flag.
module mlblock_os_array
  import mlblock_os_pkg::*;
#(
  parameter int PE_H  = 4,
  parameter int PE_W  = 4,
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int RES_W = 32,
  parameter int K_W   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic config_en,
  input  logic config_in,
  output logic config_out,
  input  logic start,
  output logic busy,
  output logic done,
  output logic sat_flag,
  mlblock_os_array_if.slave io
);
  localparam int RW      = (PE_H > 1) ? $clog2(PE_H) : 1;
  localparam int CFG_LEN = cfg_len(K_W);
  localparam int FL_N    = PE_H + PE_W;
  localparam int FL_W    = $clog2(FL_N + 1);

  state_t             state;
  state_t             nstate;
  logic [CFG_LEN-1:0] cfg;
  logic               sgn;
  logic [K_W-1:0]     k_len;
  logic [K_W-1:0]     beat_cnt;
  logic [FL_W-1:0]    fl_cnt;
  logic [RW-1:0]      row;
  logic               fire;
  logic               go;
  logic               beat_last;
  logic               fl_last;
  logic               row_last;

  logic [A_W-1:0]   ah  [PE_H][PE_W+1];
  logic             av  [PE_H][PE_W+1];
  logic [B_W-1:0]   bd  [PE_H+1][PE_W];
  logic             bv  [PE_H+1][PE_W];
  logic [RES_W-1:0] acc [PE_H][PE_W];
  logic [PE_H*PE_W-1:0] sat_v;

  assign sgn        = cfg[K_W];
  assign k_len      = cfg[K_W-1:0];
  assign config_out = cfg[CFG_LEN-1];
  assign go         = start && (k_len != '0);
  assign fire       = io.in_valid && io.in_ready;
  assign beat_last  = beat_cnt == k_len - K_W'(1);
  assign fl_last    = fl_cnt == FL_W'(FL_N - 1);
  assign row_last   = row == RW'(PE_H - 1);
  assign sat_flag   = |sat_v;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  if (go) nstate = RUN;
      RUN:   if (fire && beat_last) nstate = FLUSH;
      FLUSH: if (fl_last) nstate = DRAIN;
      DRAIN: if (io.res_ready && row_last) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy         = state != IDLE;
    io.in_ready  = (state == RUN) && (beat_cnt < k_len);
    io.res_valid = state == DRAIN;
    io.res_row   = row;
    done         = (state == DRAIN) && io.res_ready && row_last;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg      <= '0;
      beat_cnt <= '0;
      fl_cnt   <= '0;
      row      <= '0;
    end else begin
      if (state == IDLE && config_en)
        cfg <= {cfg[CFG_LEN-2:0], config_in};
      if (state == IDLE)
        beat_cnt <= '0;
      else if (fire)
        beat_cnt <= beat_cnt + K_W'(1);
      fl_cnt <= (state == FLUSH) ? fl_cnt + FL_W'(1) : '0;
      if (state == DRAIN && io.res_ready)
        row <= row_last ? '0 : row + RW'(1);
    end
  end

  // lane i of a is delayed i cycles, lane j of b j cycles
  for (genvar i = 0; i < PE_H; i++) begin : g_ask
    if (i == 0) begin : g_d0
      assign ah[i][0] = io.a[i*A_W +: A_W];
      assign av[i][0] = fire;
    end else begin : g_dn
      logic [A_W-1:0] d [i];
      logic           v [i];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < i; k++) begin
            d[k] <= '0;
            v[k] <= 1'b0;
          end
        end else begin
          d[0] <= io.a[i*A_W +: A_W];
          v[0] <= fire;
          for (int k = 1; k < i; k++) begin
            d[k] <= d[k-1];
            v[k] <= v[k-1];
          end
        end
      end
      assign ah[i][0] = d[i-1];
      assign av[i][0] = v[i-1];
    end
  end

  for (genvar j = 0; j < PE_W; j++) begin : g_bsk
    if (j == 0) begin : g_d0
      assign bd[0][j] = io.b[j*B_W +: B_W];
      assign bv[0][j] = fire;
    end else begin : g_dn
      logic [B_W-1:0] d [j];
      logic           v [j];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < j; k++) begin
            d[k] <= '0;
            v[k] <= 1'b0;
          end
        end else begin
          d[0] <= io.b[j*B_W +: B_W];
          v[0] <= fire;
          for (int k = 1; k < j; k++) begin
            d[k] <= d[k-1];
            v[k] <= v[k-1];
          end
        end
      end
      assign bd[0][j] = d[j-1];
      assign bv[0][j] = v[j-1];
    end
  end

  for (genvar i = 0; i < PE_H; i++) begin : g_row
    for (genvar j = 0; j < PE_W; j++) begin : g_col
      mlblock_os_pe #(
        .A_W   (A_W),
        .B_W   (B_W),
        .RES_W (RES_W)
      ) u_pe (
        .clk    (clk),
        .reset  (reset),
        .clr    (done),
        .sgn    (sgn),
        .a_in   (ah[i][j]),
        .a_vin  (av[i][j]),
        .b_in   (bd[i][j]),
        .b_vin  (bv[i][j]),
        .a_out  (ah[i][j+1]),
        .a_vout (av[i][j+1]),
        .b_out  (bd[i+1][j]),
        .b_vout (bv[i+1][j]),
        .acc    (acc[i][j]),
        .sat    (sat_v[i*PE_W+j])
      );
    end
  end

  always_comb begin
    io.res = '0;
    for (int j = 0; j < PE_W; j++)
      io.res[j*RES_W +: RES_W] = acc[row][j];
  end

endmodule

// File: tb/tb_mlblock_os_array.sv
// Scoreboard bench for mlblock_os_array (32-bit and 16-bit result builds).
// Saturation expectations follow MLBLOCK_RES_SAT_EN.
module tb_mlblock_os_array;

`ifdef MLBLOCK_RES_SAT_EN
  localparam logic [15:0] SAT_LANE = 16'h7FFF;
  localparam logic        SAT_F    = 1'b1;
`else
  localparam logic [15:0] SAT_LANE = 16'hBD03;
  localparam logic        SAT_F    = 1'b0;
`endif

  typedef struct {
    logic [1:0]   row;
    logic [127:0] val;
  } exp_t;

  typedef struct {
    logic [1:0]  row;
    logic [63:0] val;
  } exp2_t;

  logic clk = 1'b0;
  logic rst;
  logic config_en, config_in, start;
  logic cfg_out, busy, done, sat_flag;
  logic cfg_out2, busy2, done2, sat2;

  int checks = 0;
  int passed = 0;
  int done_cnt = 0;
  int ndone = 0;
  int stall_row = 0;
  int stall_cycles = 0;
  int stall_used = 0;

  exp_t  sb [$];
  exp2_t q2 [$];
  logic [31:0] ba [8];
  logic [31:0] bb [8];

  mlblock_os_array_if #(.RES_W(32)) io ();
  mlblock_os_array_if #(.RES_W(16)) io2 ();

  mlblock_os_array #(
    .PE_H(4), .PE_W(4), .A_W(8), .B_W(8),
    .RES_W(32), .K_W(16)
  ) dut (
    .clk(clk), .reset(rst),
    .config_en(config_en), .config_in(config_in),
    .config_out(cfg_out), .start(start),
    .busy(busy), .done(done), .sat_flag(sat_flag),
    .io(io)
  );

  mlblock_os_array #(
    .PE_H(4), .PE_W(4), .A_W(8), .B_W(8),
    .RES_W(16), .K_W(16)
  ) dut2 (
    .clk(clk), .reset(rst),
    .config_en(config_en), .config_in(config_in),
    .config_out(cfg_out2), .start(start),
    .busy(busy2), .done(done2), .sat_flag(sat2),
    .io(io2)
  );

  assign io2.in_valid  = io.in_valid;
  assign io2.a         = io.a;
  assign io2.b         = io.b;
  assign io2.res_ready = io.res_ready;

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // result-ready driver with a programmable stall on one row
  always @(posedge clk) begin
    #1;
    if (io.res_valid && io.res_row == stall_row[1:0]
        && stall_used < stall_cycles) begin
      io.res_ready = 1'b0;
      stall_used++;
    end else begin
      io.res_ready = 1'b1;
    end
  end

  logic         hold_prev = 1'b0;
  logic [1:0]   prow;
  logic [127:0] pres;

  always @(negedge clk) begin
    exp_t e;
    if (io.res_valid && io.res_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected row", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("res_row", io.res_row, e.row);
        for (int j = 0; j < 4; j++)
          chk($sformatf("row%0d lane%0d", e.row, j),
              io.res[j*32 +: 32], e.val[j*32 +: 32]);
      end
    end
    if (done) begin
      done_cnt++;
      chk("done on last handshake",
          {io.res_valid && io.res_ready, io.res_row}, 3'b111);
    end
    if (hold_prev && io.res_valid) begin
      chk("stall row stable", io.res_row, prow);
      chk("stall res stable", io.res, pres);
    end
    hold_prev = io.res_valid && !io.res_ready;
    prow = io.res_row;
    pres = io.res;
  end

  always @(negedge clk) begin
    exp2_t e2;
    if (io2.res_valid && io2.res_ready && q2.size() > 0) begin
      e2 = q2.pop_front();
      chk("r16 res_row", io2.res_row, e2.row);
      for (int j = 0; j < 4; j++)
        chk($sformatf("r16 row%0d lane%0d", e2.row, j),
            io2.res[j*16 +: 16], e2.val[j*16 +: 16]);
    end
  end

  task automatic push_row(input int r, input logic [31:0] l0,
                          input logic [31:0] l1, input logic [31:0] l2,
                          input logic [31:0] l3);
    exp_t e;
    e.row = r[1:0];
    e.val = {l3, l2, l1, l0};
    sb.push_back(e);
  endtask

  task automatic uni_rows(input logic [31:0] v);
    for (int r = 0; r < 4; r++) push_row(r, v, v, v, v);
  endtask

  task automatic cfg(input logic sgn, input logic [15:0] kl);
    logic [16:0] v;
    v = {sgn, kl};
    for (int i = 16; i >= 0; i--) begin
      config_en = 1'b1;
      config_in = v[i];
      @(posedge clk); #1;
    end
    config_en = 1'b0;
    config_in = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n, input bit bub);
    int t;
    for (int k = 0; k < n; k++) begin
      io.in_valid = 1'b1;
      io.a = ba[k];
      io.b = bb[k];
      t = 0;
      @(negedge clk);
      while (!io.in_ready && t < 100) begin
        t++;
        @(negedge clk);
      end
      if (t >= 100) chk("in_ready timeout", 0, 1);
      @(posedge clk); #1;
      io.in_valid = 1'b0;
      if (bub) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy) && t < 3000) begin
      t++;
      @(negedge clk);
    end
    if (t >= 3000) chk("drain timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_distinct();
    cfg(1'b0, 16'd2);
    push_row(0, 6, 8, 10, 12);
    push_row(1, 11, 14, 17, 20);
    push_row(2, 16, 20, 24, 28);
    push_row(3, 21, 26, 31, 36);
    ba[0] = {8'd4, 8'd3, 8'd2, 8'd1};
    bb[0] = {8'd8, 8'd7, 8'd6, 8'd5};
    ba[1] = {8'd1, 8'd1, 8'd1, 8'd1};
    bb[1] = {8'd4, 8'd3, 8'd2, 8'd1};
    start_run();
    feed(2, 1'b0);
    wait_idle();
    ndone++;
    chk("distinct done count", done_cnt, ndone);
  endtask

  initial begin
    int t;
    int su;
    exp2_t e2;
    rst = 1'b1;
    config_en = 1'b0;
    config_in = 1'b0;
    start = 1'b0;
    io.in_valid = 1'b0;
    io.a = '0;
    io.b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset res_valid", io.res_valid, 0);
    chk("reset in_ready", io.in_ready, 0);
    chk("reset config_out", cfg_out, 0);
    chk("reset res", io.res, 0);
    chk("reset sat_flag", sat_flag, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // basic k_len=1, 2*3
    cfg(1'b0, 16'd1);
    uni_rows(32'd6);
    ba[0] = {4{8'd2}};
    bb[0] = {4{8'd3}};
    start_run();
    chk("busy after start", busy, 1);
    feed(1, 1'b0);
    wait_idle();
    ndone++;
    chk("basic done count", done_cnt, ndone);

    // signed 0xFF*2 x3, config_en held during RUN
    cfg(1'b1, 16'd3);
    uni_rows(32'hFFFF_FFFA);
    for (int k = 0; k < 3; k++) begin
      ba[k] = {4{8'hFF}};
      bb[k] = {4{8'h02}};
    end
    start_run();
    config_en = 1'b1;
    config_in = 1'b0;
    feed(3, 1'b0);
    config_en = 1'b0;
    chk("config frozen in run", cfg_out, 1);
    wait_idle();
    ndone++;
    chk("signed done count", done_cnt, ndone);

    // unsigned 255*2 x3
    cfg(1'b0, 16'd3);
    uni_rows(32'd1530);
    start_run();
    feed(3, 1'b0);
    wait_idle();
    ndone++;
    chk("unsigned done count", done_cnt, ndone);

    run_distinct();

    // bubbles, stall on row 1, start during DRAIN
    cfg(1'b0, 16'd4);
    push_row(0, 20, 24, 28, 32);
    push_row(1, 40, 48, 56, 64);
    push_row(2, 60, 72, 84, 96);
    push_row(3, 80, 96, 112, 128);
    for (int k = 0; k < 4; k++) begin
      ba[k] = {8'd4, 8'd3, 8'd2, 8'd1};
      bb[k] = {8'd8, 8'd7, 8'd6, 8'd5};
    end
    su = stall_used;
    stall_row = 1;
    stall_cycles = stall_used + 5;
    start_run();
    feed(4, 1'b1);
    t = 0;
    @(negedge clk);
    while (!(io.res_valid && io.res_row == 2'd1) && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) chk("row1 timeout", 0, 1);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    ndone++;
    chk("stall done count", done_cnt, ndone);
    chk("stall cycles applied", stall_used - su, 5);
    repeat (3) begin
      @(negedge clk);
      chk("start in DRAIN ignored", busy, 0);
    end
    @(posedge clk); #1;

    // k_len=0 start ignored
    cfg(1'b0, 16'd0);
    start_run();
    repeat (3) begin
      @(negedge clk);
      chk("k_len=0 busy", busy, 0);
    end
    @(posedge clk); #1;

    // reset during FLUSH
    cfg(1'b1, 16'd2);
    ba[0] = {4{8'd1}};
    bb[0] = {4{8'd1}};
    ba[1] = {4{8'd1}};
    bb[1] = {4{8'd1}};
    start_run();
    feed(2, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort busy", busy, 0);
    chk("abort res_valid", io.res_valid, 0);
    chk("abort in_ready", io.in_ready, 0);
    chk("abort done", done, 0);
    chk("abort config_out", cfg_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    config_en = 1'b1;
    config_in = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      chk("cfg cleared bit", cfg_out, 0);
      @(posedge clk); #1;
    end
    config_en = 1'b0;
    chk("abort done count", done_cnt, ndone);
    run_distinct();

    // 127*127 x3: wraps or clamps in the 16-bit build
    cfg(1'b1, 16'd3);
    uni_rows(32'd48387);
    for (int r = 0; r < 4; r++) begin
      e2.row = r[1:0];
      e2.val = {16'h0, SAT_LANE, SAT_LANE, SAT_LANE, SAT_LANE};
      e2.val[63:48] = SAT_LANE;
      q2.push_back(e2);
    end
    for (int k = 0; k < 3; k++) begin
      ba[k] = {4{8'd127}};
      bb[k] = {4{8'd127}};
    end
    start_run();
    feed(3, 1'b0);
    t = 0;
    @(negedge clk);
    while (!io2.res_valid && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) chk("r16 drain timeout", 0, 1);
    chk("r16 sat_flag", sat2, SAT_F);
    chk("r32 sat_flag", sat_flag, 0);
    @(posedge clk); #1;
    wait_idle();
    ndone++;
    chk("sat done count", done_cnt, ndone);
    chk("r16 rows drained", q2.size(), 0);
    chk("r16 sat cleared", sat2, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mlblock_os_array.md
Name: mlblock_os_array

Overview:
- Parametrised output-stationary successor to the MLBlock PE array, with a streaming front end instead of fixed wiring.
- PE_H x PE_W grid of MAC PEs; each PE(i,j) accumulates sum over k of a_i[k]*b_j[k] for a runtime-configured depth k_len.
- Adds an operand skew pipeline, valid/ready input and output handshakes, a run FSM and row-serial result drain.
- Keeps the serial config scan chain for daisy-chaining blocks.

Parameters:
- PE_H, 4, PE rows; a-vector lanes; result rows.
- PE_W, 4, PE columns; b-vector lanes; result lanes per row.
- A_W, 8, a-operand width.
- B_W, 8, b-operand width.
- RES_W, 32, accumulator and result width; must be >= A_W+B_W.
- K_W, 16, width of the k_len config field.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- config_en  in  1  shift enable for the config chain; honoured only in IDLE.
- config_in  in  1  serial config bit in.
- config_out  out  1  MSB of the config shift register.
- start  in  1  begin a run (IDLE only).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the final result row handshakes.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  operand beat accepted when in_valid && in_ready.
- a  in  PE_H*A_W  a column vector for one k step; lane i feeds row i.
- b  in  PE_W*B_W  b row vector for one k step; lane j feeds column j.
- res_valid  out  1  result row valid.
- res_ready  in  1  result row consumed.
- res  out  PE_W*RES_W  accumulators of row res_row; lane j is PE(res_row,j).
- res_row  out  max(1,clog2(PE_H))  index of the row being presented.
- sat_flag  out  1  sticky: some accumulator saturated during the current run.

Behaviour:
- Config register cfg is K_W+1 bits: {signed_mode, k_len}.
  - In IDLE with config_en high: cfg <= {cfg[K_W-1:0], config_in}.
  - config_en is ignored in all other states.
  - Shift order: signed_mode first, then k_len MSB first.
- Reset values: cfg=0, state IDLE, all accumulators, skew registers and valid bits 0, every output 0.
  - A reset mid-run aborts immediately; done does not pulse.
- IDLE:
  - start && k_len!=0 -> RUN; beat counter cleared.
  - start with k_len==0 is ignored.
- RUN:
  - in_ready = (beat_cnt < k_len).
  - Each accepted beat increments beat_cnt.
  - The cycle after the k_len-th beat is accepted -> FLUSH.
  - in_valid low inserts a bubble; the pipeline advances every cycle regardless.
- Skew datapath:
  - Operand a_i enters row i at column 0 and moves one PE right per cycle.
  - Operand b_j enters column j at row 0 and moves one PE down per cycle.
  - Each operand carries a valid bit.
  - A beat's a_i and b_j meet at PE(i,j) after i+j register stages.
  - A PE accumulates only when both incoming operands are valid.
- FLUSH: lasts exactly PE_H+PE_W cycles, then -> DRAIN with res_row=0.
- DRAIN:
  - res_valid is held high with stable res and res_row until res_ready.
  - Each handshake advances res_row.
  - The handshake on row PE_H-1 clears all accumulators and sat_flag, pulses done, and returns the FSM to IDLE.
  - start is ignored while busy.
- Arithmetic:
  - signed_mode=1: two's-complement product, sign-extended to RES_W.
  - signed_mode=0: unsigned product, zero-extended.
  - Accumulation wraps modulo 2^RES_W unless MLBLOCK_RES_SAT_EN is defined.
- Result row order is 0..PE_H-1; no skipping, no repeats.

Optional Feature:
- Macro: MLBLOCK_RES_SAT_EN.
- Defined: accumulators saturate instead of wrapping.
  - Signed mode clamps to [-2^(RES_W-1), 2^(RES_W-1)-1].
  - Unsigned mode clamps to 2^RES_W-1.
  - Any clamp event sets sat_flag.
- Undefined: accumulation wraps and sat_flag is tied to 0.

Decomposition:
- Package mlblock_os_pkg:
  - FSM state enum {IDLE, RUN, FLUSH, DRAIN}.
  - CFG_LEN = K_W+1 helper.
  - Saturating-add function.
- Sub-module mlblock_os_pe: a/b pass-through registers with valid bits, the multiplier, the accumulator (with optional saturation) and a clear input.
- Top level: config chain, FSM, counters, row drain mux.

Test Plan:
- Basic run, 4x4: shift cfg {0, k_len=1}; one beat with all a=2, all b=3 -> one row per handshake, every res lane =6, rows 0..3 in order, done pulses once.
- Signed vs unsigned, k_len=3, all a=0xFF, all b=2:
  - signed_mode=1 -> every lane 0xFFFFFFFA (-6).
  - signed_mode=0 -> every lane 1530.
- Backpressure: k_len=4 with in_valid toggling 1,0,1,0... and res_ready low for 5 cycles on row 1 -> sums match the unstalled run; res and res_row stay stable while stalled.
- Boundaries:
  - start with k_len=0 -> busy stays 0.
  - config_en during RUN -> config_out unchanged.
  - start during DRAIN -> ignored.
- Reset: assert reset during FLUSH -> busy, res_valid, in_ready and done are 0 immediately; cfg reads 0 via config_out; a subsequent configured run gives correct results.
- Saturation, RES_W=16, signed, k_len=3, all a=127, all b=127:
  - with MLBLOCK_RES_SAT_EN -> lanes 0x7FFF, sat_flag=1.
  - without it -> lanes 0xBD03, sat_flag=0.
